// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter for N requesters with a per-grant hold quantum.
// Grants are registered, one-hot and work-conserving with no dead cycle between owners.
module rr_arbiter_param #(
  parameter  int N       = 4,
  parameter  int QUANTUM = 4,
  localparam int IDXW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    request,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx
);

  localparam int              CNTW     = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(QUANTUM - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);
  localparam logic [N-1:0]    ONE_HOT0 = N'(1);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e          state_q;
  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] idx_q;
  logic [CNTW-1:0] cnt_q;
  logic [N-1:0]    grant_q;
  logic            valid_q;

  logic            search_hit;
  logic [IDXW-1:0] search_idx;
  logic [IDXW-1:0] ptr_d;
  logic            hold;

  // Scan from the highest offset down so the last hit is the first requester at or after ptr.
  always_comb begin : search
    int              cand;
    logic [IDXW-1:0] cand_idx;
    // NOTE: every variable gets a default up front so no path leaves it unassigned (no latch).
    cand       = 0;
    cand_idx   = '0;
    search_hit = 1'b0;
    search_idx = ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDXW'(cand);
      if (request[cand_idx]) begin
        search_hit = 1'b1;
        search_idx = cand_idx;
      end
    end
  end

  // Wrap by comparison so non-power-of-two N works.
  assign ptr_d = (search_idx == IDX_LAST) ? '0 : search_idx + IDXW'(1);
  assign hold  = request[idx_q] && (cnt_q < CNT_MAX);

  // NOTE: asynchronous reset in the sensitivity list and non-blocking updates for all state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (search_hit) begin
            state_q <= S_GRANT;
            grant_q <= ONE_HOT0 << search_idx;
            idx_q   <= search_idx;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            ptr_q   <= ptr_d;
          end
        end
        S_GRANT: begin
          if (hold) begin
            cnt_q <= cnt_q + CNTW'(1);
          end else if (search_hit) begin
            // Quantum expiry or release: hand over, or re-grant the same owner if alone.
            grant_q <= ONE_HOT0 << search_idx;
            idx_q   <= search_idx;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            ptr_q   <= ptr_d;
          end else begin
            state_q <= S_IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Bench for rr_arbiter_param: three configurations (4/4, 3/1, 5/2) checked against an
// integer round-robin model plus directed expectations for the key scenarios.
module tb_rr_arbiter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req_a, gnt_a;
  logic       val_a;
  logic [1:0] idx_a;
  logic [2:0] req_b, gnt_b;
  logic       val_b;
  logic [1:0] idx_b;
  logic [4:0] req_c, gnt_c;
  logic       val_c;
  logic [2:0] idx_c;

  rr_arbiter_param #(.N(4), .QUANTUM(4)) dut_a (
    .clk(clk), .rst(rst), .request(req_a),
    .grant(gnt_a), .grant_valid(val_a), .grant_idx(idx_a)
  );
  rr_arbiter_param #(.N(3), .QUANTUM(1)) dut_b (
    .clk(clk), .rst(rst), .request(req_b),
    .grant(gnt_b), .grant_valid(val_b), .grant_idx(idx_b)
  );
  rr_arbiter_param #(.N(5), .QUANTUM(2)) dut_c (
    .clk(clk), .rst(rst), .request(req_c),
    .grant(gnt_c), .grant_valid(val_c), .grant_idx(idx_c)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Model state per configuration: 0 = N4/Q4, 1 = N3/Q1, 2 = N5/Q2. hold < 0 means idle.
  int m_ptr[3], m_hold[3], m_cnt[3], m_last[3];

  function automatic void m_reset_all();
    for (int d = 0; d < 3; d++) begin
      m_ptr[d] = 0; m_hold[d] = -1; m_cnt[d] = 0; m_last[d] = 0;
    end
  endfunction

  function automatic bit bit_of(logic [7:0] v, int i);
    return v[3'(i)];
  endfunction

  // One clock of the rules: keep the owner while it asks and has quantum left,
  // otherwise pick the first requester cyclically from the pointer.
  function automatic void m_step(int d, logic [7:0] req, int n, int q);
    int j;
    if (m_hold[d] >= 0 && bit_of(req, m_hold[d]) && m_cnt[d] < q - 1) begin
      m_cnt[d]++;
      return;
    end
    j = -1;
    for (int k = 0; k < n; k++)
      if (j < 0 && bit_of(req, (m_ptr[d] + k) % n)) j = (m_ptr[d] + k) % n;
    if (j >= 0) begin
      m_hold[d] = j; m_cnt[d] = 0; m_ptr[d] = (j + 1) % n; m_last[d] = j;
    end else begin
      m_hold[d] = -1;
    end
  endfunction

  function automatic logic [7:0] m_gnt(int d);
    return (m_hold[d] < 0) ? 8'd0 : (8'd1 << m_hold[d]);
  endfunction

  function automatic logic [11:0] m_vec(int d);
    return {m_gnt(d), (m_hold[d] >= 0), 3'(m_last[d])};
  endfunction

  task automatic step();
    m_step(0, 8'(req_a), 4, 4);
    m_step(1, 8'(req_b), 3, 1);
    m_step(2, 8'(req_c), 5, 2);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = '0; req_b = '0; req_c = '0;
    m_reset_all();
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({gnt_a, val_a, idx_a} !== 7'd0)
      $display("FAIL reset_a: got %b/%b/%0d want 0000/0/0", gnt_a, val_a, idx_a);
    else pass_cnt++;
    chk_cnt++;
    if ({gnt_b, val_b, idx_b} !== 6'd0)
      $display("FAIL reset_b: got %b/%b/%0d want 000/0/0", gnt_b, val_b, idx_b);
    else pass_cnt++;
    chk_cnt++;
    if ({gnt_c, val_c, idx_c} !== 9'd0)
      $display("FAIL reset_c: got %b/%b/%0d want 00000/0/0", gnt_c, val_c, idx_c);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_async_mid_grant();
    req_a = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_cnt++;
      if ({4'd0, gnt_a, val_a, 1'b0, idx_a} !== m_vec(0))
        $display("FAIL async_pre cyc %0d: got %b idx %0d want %b idx %0d",
                 k, gnt_a, idx_a, m_gnt(0), m_last[0]);
      else pass_cnt++;
    end
    #3;
    rst = 1'b1;
    m_reset_all();
    #1;
    chk_cnt++;
    if (gnt_a !== 4'b0000 || val_a !== 1'b0)
      $display("FAIL async_clear: got %b/%b want 0000/0 before next edge", gnt_a, val_a);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk_cnt++;
    if (gnt_a !== 4'b0001 || val_a !== 1'b1 || idx_a !== 2'd0)
      $display("FAIL async_first: got %b/%b/%0d want 0001/1/0", gnt_a, val_a, idx_a);
    else pass_cnt++;
  endtask

  task automatic test_lone();
    do_reset();
    req_a = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      step();
      chk_cnt++;
      if (gnt_a !== 4'b0001 || val_a !== 1'b1 || idx_a !== 2'd0)
        $display("FAIL lone cyc %0d: got %b/%b/%0d want 0001/1/0", k, gnt_a, val_a, idx_a);
      else pass_cnt++;
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    do_reset();
    req_a = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step();
      exp = 4'b0001 << ((k / 4) % 4);
      chk_cnt++;
      if (gnt_a !== exp || val_a !== 1'b1)
        $display("FAIL contention cyc %0d: got %b want %b", k, gnt_a, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_skip();
    do_reset();
    req_a = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_cnt++;
      if (gnt_a !== 4'b0001)
        $display("FAIL skip_hold cyc %0d: got %b want 0001", k, gnt_a);
      else pass_cnt++;
    end
    req_a = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_cnt++;
      if (gnt_a !== 4'b0100 || val_a !== 1'b1 || idx_a !== 2'd2)
        $display("FAIL skip_move cyc %0d: got %b/%b/%0d want 0100/1/2", k, gnt_a, val_a, idx_a);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap_idle();
    do_reset();
    req_a = 4'b1000;
    step();
    chk_cnt++;
    if (gnt_a !== 4'b1000 || idx_a !== 2'd3)
      $display("FAIL wrap_grant3: got %b idx %0d want 1000 idx 3", gnt_a, idx_a);
    else pass_cnt++;
    req_a = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_cnt++;
      if (gnt_a !== 4'b0000 || val_a !== 1'b0 || idx_a !== 2'd3)
        $display("FAIL wrap_idle cyc %0d: got %b/%b/%0d want 0000/0/3", k, gnt_a, val_a, idx_a);
      else pass_cnt++;
    end
    req_a = 4'b1001;
    step();
    chk_cnt++;
    if (gnt_a !== 4'b0001 || val_a !== 1'b1 || idx_a !== 2'd0)
      $display("FAIL wrap_ptr: got %b/%b/%0d want 0001/1/0", gnt_a, val_a, idx_a);
    else pass_cnt++;
  endtask

  task automatic test_n3_rotate();
    logic [2:0] exp;
    do_reset();
    req_b = 3'b111;
    for (int k = 0; k < 9; k++) begin
      step();
      exp = 3'b001 << (k % 3);
      chk_cnt++;
      if (gnt_b !== exp || val_b !== 1'b1)
        $display("FAIL n3_rotate cyc %0d: got %b want %b", k, gnt_b, exp);
      else pass_cnt++;
    end
    req_b = 3'b010;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_cnt++;
      if (gnt_b !== 3'b010)
        $display("FAIL n3_single cyc %0d: got %b want 010", k, gnt_b);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_n5();
    int         waited[5];
    int         max_wait;
    logic [4:0] prev;
    do_reset();
    max_wait = 0;
    for (int i = 0; i < 5; i++) waited[i] = 0;
    req_c = 5'($urandom_range(0, 31));
    for (int k = 0; k < 400; k++) begin
      // Sticky requests: each bit flips with probability 1/4 to build real contention.
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 3) == 0) req_c[i] = ~req_c[i];
      req_a = 4'($urandom_range(0, 15));
      prev = req_c;
      step();
      chk_cnt++;
      if ({3'd0, gnt_c, val_c, idx_c} !== m_vec(2))
        $display("FAIL rand_model cyc %0d: got %b/%b/%0d want %b/%0d/%0d",
                 k, gnt_c, val_c, idx_c, m_gnt(2), (m_hold[2] >= 0), m_last[2]);
      else pass_cnt++;
      chk_cnt++;
      if (($countones(gnt_c) > 1) || (val_c !== (gnt_c != 0)) || ((gnt_c & ~prev) != 0))
        $display("FAIL rand_invariant cyc %0d: grant %b valid %b prior request %b",
                 k, gnt_c, val_c, prev);
      else pass_cnt++;
      chk_cnt++;
      if ({4'd0, gnt_a, val_a, 1'b0, idx_a} !== m_vec(0))
        $display("FAIL rand_a cyc %0d: got %b idx %0d want %b idx %0d",
                 k, gnt_a, idx_a, m_gnt(0), m_last[0]);
      else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
        waited[i] = (prev[i] && !gnt_c[i]) ? waited[i] + 1 : 0;
        if (waited[i] > max_wait) max_wait = waited[i];
      end
    end
    chk_cnt++;
    if (max_wait > 8)
      $display("FAIL rand_starvation: longest wait %0d cycles, limit 8", max_wait);
    else pass_cnt++;
  endtask

  initial begin
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    m_reset_all();
    test_reset();
    test_async_mid_grant();
    test_lone();
    test_contention();
    test_skip();
    test_wrap_idle();
    test_n3_rotate();
    test_random_n5();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
- Parametrised round-robin arbiter for N requesters sharing one resource.
- Grants are registered and one-hot. Each grant is held for up to QUANTUM cycles.
- Idle requesters are skipped (work-conserving). Rotation continues back-to-back with no dead cycle.
- Used in front of shared buses and memory ports wherever more than four masters contend.

Parameters:
- N, 4, number of requesters; legal range N >= 2.
- QUANTUM, 4, maximum consecutive cycles one requester may hold the grant while others wait; legal range QUANTUM >= 1.
- IDXW, max(1,$clog2(N)), width of grant_idx; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- request  input  N  request vector; bit i high = requester i wants the resource.
- grant  output  N  one-hot grant, registered; all zeros when idle.
- grant_valid  output  1  high when grant is non-zero; registered.
- grant_idx  output  IDXW  binary index of the granted requester; holds its last value when idle.

Behaviour:
- Reset (asynchronous, while rst=1):
  - grant=0, grant_valid=0, grant_idx=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
  - Asserting rst mid-grant clears outputs immediately, without waiting for a clock edge.
  - First grant after rst deasserts is on the first rising edge with request!=0.
- State machine, two states: IDLE and GRANT.
- Arbitration search:
  - Cyclic search from ptr upward, wrapping from N-1 to 0.
  - Selects the first index j with request[j]=1.
  - Pure function of request and ptr; evaluated every cycle.
- IDLE:
  - request==0: stay in IDLE, outputs zero.
  - Otherwise on the next edge: grant[j]=1, grant_idx=j, grant_valid=1, counter=0, ptr=(j+1) mod N, go to GRANT.
  - Latency from request to grant is 1 cycle.
- GRANT, holding index i:
  - request[i]=1, counter < QUANTUM-1: keep grant i, counter++.
  - request[i]=1, counter == QUANTUM-1, another request pending: issue the search result (search starts at ptr=i+1), counter=0, ptr updated.
  - request[i]=1, counter == QUANTUM-1, no other request: re-grant i with counter=0. No gap cycle.
  - request[i]=0, other request pending: grant moves to the search result on the next edge. No idle cycle between grants.
  - request[i]=0, request==0: go to IDLE on the next edge; grant=0, grant_valid=0, grant_idx holds i.
  - The grant is registered, so a requester that drops request still sees grant for the cycle in which it dropped. This is required behaviour.
- QUANTUM=1:
  - With multiple requesters active, the grant rotates every cycle.
  - A single active requester keeps a continuous grant.
- Pointer update:
  - ptr updates only when a new grant is issued, to (granted index + 1) mod N with explicit wrap.
  - ptr is never reset by IDLE.
- Invariants:
  - grant is one-hot or zero.
  - grant_valid == |grant.
  - grant_idx matches grant whenever grant_valid=1.
  - The grant is never given to an index whose request was low in the cycle before the edge.
- Counter:
  - Width max(1,$clog2(QUANTUM)).
  - Saturates at QUANTUM-1; never wraps while still holding the same grant.
- Non-power-of-two N (e.g. 3, 5) is supported; index wrap uses compare-to-N-1, not bit truncation.

Test Plan:
- Scenarios 1-5 use N=4, QUANTUM=4.
1. Async reset mid-grant: request=1111; after 6 cycles assert rst between clock edges -> grant=0000, grant_valid=0 within the same cycle. After release with request=1111 -> grant=0001 on the first edge.
2. Lone requester: request=0001 held 20 cycles -> grant=0001 continuously from cycle 1, no zero cycle at quantum boundaries; grant_idx=0.
3. Full contention: request=1111 held -> grant sequence 0001×4, 0010×4, 0100×4, 1000×4, then 0001×4 (wrap).
4. Early release and skip: request=0101; requester 0 granted; request[0] drops after 2 grant cycles -> grant=0100 on the next edge, with no idle cycle. Requester 1 (idle) is skipped.
5. Wrap and idle pointer retention:
   - Grant 1000 then request=0000 -> grant=0000 next edge, grant_idx stays 3.
   - Later request=1001 -> grant=0001, because ptr wrapped to 0.
6. Parameter sweep:
   - N=3, QUANTUM=1, request=111 -> grant rotates 001, 010, 100, 001 every cycle.
   - N=5, QUANTUM=2 random stimulus: checker asserts one-hot grant, no grant to a non-requester, and no starvation beyond (N-1)*QUANTUM cycles.
